// File: rtl/sort_serializer.sv
// Serializes one sorted NUM_VALS-word vector into a valid/ready word stream.
// Each word is tagged with its index and a last flag.
module sort_serializer #(
  parameter int unsigned NUM_VALS = 5,
  parameter int unsigned SIZE     = 16,
  localparam int unsigned IDX_W   = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_VALS*SIZE-1:0] vec_in,
  input  logic                     vec_valid,
  output logic                     vec_ready,
  output logic [SIZE-1:0]          dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [IDX_W-1:0]         dout_idx,
  output logic                     dout_last
);

  localparam int unsigned VEC_W    = NUM_VALS * SIZE;
  localparam int unsigned LAST_IDX = NUM_VALS - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [VEC_W-1:0] vec_q;
  logic [IDX_W-1:0] next_idx;
  logic             load;

  // Word k sits at the left end of the packed vector for k = 0.
  function automatic logic [SIZE-1:0] word_at(input logic [VEC_W-1:0] v,
                                              input logic [IDX_W-1:0] k);
    logic [VEC_W-1:0] sh;
    sh = v >> (SIZE * (LAST_IDX - 32'(k)));
    return sh[SIZE-1:0];
  endfunction

  assign vec_ready = !rst && ((state == IDLE) || (dout_valid && dout_ready && dout_last));
  assign load      = vec_valid && vec_ready;
  assign next_idx  = dout_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec_q      <= '0;
      dout       <= '0;
      dout_idx   <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (load) begin
      state      <= SEND;
      vec_q      <= vec_in;
      dout       <= word_at(vec_in, IDX_W'(0));
      dout_idx   <= '0;
      dout_valid <= 1'b1;
      dout_last  <= (NUM_VALS == 1);
    end else if (state == SEND && dout_ready) begin
      if (dout_last) begin
        // dout deliberately keeps the last word when going idle.
        state      <= IDLE;
        dout_idx   <= '0;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end else begin
        dout       <= word_at(vec_q, next_idx);
        dout_idx   <= next_idx;
        dout_last  <= (next_idx == IDX_W'(LAST_IDX));
      end
    end
  end

endmodule

// File: tb/tb_sort_serializer.sv
// Directed bench for sort_serializer: NUM_VALS=5 and NUM_VALS=1 instances.
module tb_sort_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] vec_in;
  logic        vec_valid;
  logic        vec_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  dout_idx;
  logic        dout_last;

  logic [15:0] v1_in;
  logic        v1_valid;
  logic        v1_ready;
  logic [15:0] d1;
  logic        d1_valid;
  logic        d1_ready;
  logic [0:0]  d1_idx;
  logic        d1_last;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sort_serializer #(.NUM_VALS(5), .SIZE(16)) u5 (
    .clk(clk), .rst(rst), .vec_in(vec_in), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_idx(dout_idx), .dout_last(dout_last)
  );

  sort_serializer #(.NUM_VALS(1), .SIZE(16)) u1 (
    .clk(clk), .rst(rst), .vec_in(v1_in), .vec_valid(v1_valid),
    .vec_ready(v1_ready), .dout(d1), .dout_valid(d1_valid),
    .dout_ready(d1_ready), .dout_idx(d1_idx), .dout_last(d1_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic word5(input string tag, input int d, input int idx, input bit last);
    chk({tag, " valid"}, 32'(dout_valid), 32'd1);
    chk({tag, " dout"},  32'(dout), 32'(d));
    chk({tag, " idx"},   32'(dout_idx), 32'(idx));
    chk({tag, " last"},  32'(dout_last), 32'(last));
  endtask

  task automatic idle5(input string tag, input int d);
    chk({tag, " valid"}, 32'(dout_valid), 32'd0);
    chk({tag, " idx"},   32'(dout_idx), 32'd0);
    chk({tag, " last"},  32'(dout_last), 32'd0);
    chk({tag, " dout"},  32'(dout), 32'(d));
  endtask

  function automatic logic [79:0] pk(input logic [15:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; vec_in = '0; vec_valid = 1'b0; dout_ready = 1'b1;
    v1_in = '0; v1_valid = 1'b0; d1_ready = 1'b1;
    tick();
    tick();
    // reset state
    chk("rst vec_ready", 32'(vec_ready), 32'd0);
    idle5("rst", 0);
    chk("rst u1 valid", 32'(d1_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst vec_ready", 32'(vec_ready), 32'd1);

    // 1: basic stream 1..5
    vec_in = pk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      word5($sformatf("t1 w%0d", k), k + 1, k, k == 4);
      chk($sformatf("t1 vec_ready w%0d", k), 32'(vec_ready), 32'(k == 4));
      tick();
    end
    idle5("t1 end", 5);

    // 2: backpressure at idx 1
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    word5("t2 w0", 1, 0, 1'b0);
    tick();
    dout_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      word5($sformatf("t2 stall%0d", s), 2, 1, 1'b0);
    end
    dout_ready = 1'b1;
    tick();
    word5("t2 w2", 3, 2, 1'b0);
    tick();
    word5("t2 w3", 4, 3, 1'b0);
    tick();
    word5("t2 w4", 5, 4, 1'b1);
    tick();
    idle5("t2 end", 5);

    // 3: back-to-back vectors
    vec_in = pk(16'd10, 16'd20, 16'd30, 16'd40, 16'd50);
    vec_valid = 1'b1;
    tick();
    vec_in = pk(16'd60, 16'd70, 16'd80, 16'd90, 16'd100);
    for (int k = 0; k < 5; k++) begin
      #1;
      word5($sformatf("t3 a%0d", k), 10 * (k + 1), k, k == 4);
      chk($sformatf("t3 vec_ready a%0d", k), 32'(vec_ready), 32'(k == 4));
      tick();
    end
    vec_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      word5($sformatf("t3 b%0d", k), 10 * (k + 6), k, k == 4);
      tick();
    end
    idle5("t3 end", 100);

    // 4: reset mid-vector
    vec_in = pk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    tick();
    tick();
    word5("t4 pre", 3, 2, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4 vec_ready in rst", 32'(vec_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    idle5("t4 after rst", 0);
    chk("t4 vec_ready after rst", 32'(vec_ready), 32'd1);
    vec_in = pk(16'd11, 16'd12, 16'd13, 16'd14, 16'd15);
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      word5($sformatf("t4 w%0d", k), 11 + k, k, k == 4);
      tick();
    end
    idle5("t4 end", 15);

    // 5: input isolation after acceptance
    vec_in = pk(16'd21, 16'd22, 16'd23, 16'd24, 16'd25);
    vec_valid = 1'b1;
    tick();
    vec_in = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      word5($sformatf("t5 w%0d", k), 21 + k, k, k == 4);
      chk($sformatf("t5 vec_ready w%0d", k), 32'(vec_ready), 32'(k == 4));
      if (k == 4) vec_valid = 1'b0;
      tick();
    end
    idle5("t5 end", 25);

    // 6: NUM_VALS=1
    v1_in = 16'd7;
    v1_valid = 1'b1;
    #1;
    chk("t6 ready idle", 32'(v1_ready), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t6 valid%0d", k), 32'(d1_valid), 32'd1);
      chk($sformatf("t6 dout%0d", k), 32'(d1), 32'(7 + k));
      chk($sformatf("t6 idx%0d", k), 32'(d1_idx), 32'd0);
      chk($sformatf("t6 last%0d", k), 32'(d1_last), 32'd1);
      chk($sformatf("t6 ready%0d", k), 32'(v1_ready), 32'd1);
      if (k < 2) v1_in = 16'(8 + k);
      else v1_valid = 1'b0;
      tick();
    end
    chk("t6 end valid", 32'(d1_valid), 32'd0);
    chk("t6 end last", 32'(d1_last), 32'd0);
    chk("t6 end dout", 32'(d1), 32'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
